// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: parameter defaults and
// IF state encodings.
package instr_fetch_stage_pkg;

  localparam int unsigned IfAddrW    = 32;
  localparam logic [31:0] IfResetPc  = 32'h0000_0000;
  localparam logic [31:0] IfNopInstr = 32'h0000_0000;  // sll $0,$0,0

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } if_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for an instruction word that returns from memory while decode
// is stalled; clear has priority over load, load over drain.
module fetch_skid_buffer #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic              i_clear,
  input  logic [31:0]       i_instr,
  input  logic [ADDR_W-1:0] i_pc_plus4,
  output logic              o_valid,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_pc_plus4
);

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc_plus4;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc_plus4 <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage of the 5-stage MIPS pipe: PC, synchronous imem request, and the IF/ID register,
// with decode stall (skid-buffered) and branch/jump redirect with flush.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned        ADDR_W    = IfAddrW,
  parameter logic [ADDR_W-1:0]  RESET_PC  = IfResetPc,
  parameter logic [31:0]        NOP_INSTR = IfNopInstr
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] pc_plus4_out,
  output logic              valid_out
);

  if_state_e         r_state, w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc4;
  logic              r_drop;
  logic              r_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc_plus4;

  logic              w_issue;
  logic              w_ret_valid;
  logic [ADDR_W-1:0] w_target;
  logic              w_skid_valid;
  logic [31:0]       w_skid_instr;
  logic [ADDR_W-1:0] w_skid_pc4;
  logic [1:0]        w_unused_target_lsb;

  assign w_unused_target_lsb = redirect_target[1:0];
  assign w_target            = {redirect_target[ADDR_W-1:2], 2'b00};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  w_state_next = StFetch;
      StFetch: if (stall && !redirect) w_state_next = StHold;
      StHold:  if (redirect || !stall) w_state_next = StFetch;
      default: w_state_next = StFetch;
    endcase
  end

  // The release cycle out of StHold issues too, so the skid drains alongside a fresh fetch.
  assign w_issue   = (r_state != StIdle) && !stall && !redirect;
  assign imem_en   = w_issue;
  assign imem_addr = r_pc;

  // A word returning the cycle after a redirect belongs to the abandoned path.
  assign w_ret_valid = r_inflight && !r_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      r_pc           <= RESET_PC;
      r_inflight     <= 1'b0;
      r_inflight_pc4 <= '0;
      r_drop         <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_issue;
      r_drop     <= redirect;
      if (redirect) begin
        r_pc <= w_target;
      end else if (w_issue) begin
        r_pc           <= r_pc + ADDR_W'(4);
        r_inflight_pc4 <= r_pc + ADDR_W'(4);
      end
    end
  end

  fetch_skid_buffer #(
    .ADDR_W (ADDR_W)
  ) u_skid (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (stall && !redirect && w_ret_valid),
    .i_drain    (!stall && !redirect && w_skid_valid),
    .i_clear    (redirect),
    .i_instr    (imem_rdata),
    .i_pc_plus4 (r_inflight_pc4),
    .o_valid    (w_skid_valid),
    .o_instr    (w_skid_instr),
    .o_pc_plus4 (w_skid_pc4)
  );

  // IF/ID register: redirect > stall > advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= '0;
    end else if (redirect) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (!stall) begin
      if (w_skid_valid) begin
        r_valid    <= 1'b1;
        r_instr    <= w_skid_instr;
        r_pc_plus4 <= w_skid_pc4;
      end else if (w_ret_valid) begin
        r_valid    <= 1'b1;
        r_instr    <= imem_rdata;
        r_pc_plus4 <= r_inflight_pc4;
      end else begin
        r_valid <= 1'b0;
        r_instr <= NOP_INSTR;
      end
    end
  end

  assign valid_out    = r_valid;
  assign instr_out    = r_instr;
  assign pc_plus4_out = r_pc_plus4;

endmodule
